// File: rtl/cam_line_capture.sv
// Camera capture stage: oversamples the camera bus into CLK, pairs bytes into
// RGB565 line-buffer writes. Optional: CAM_LINE_CAPTURE_TEST_PATTERN_EN.
module cam_line_capture #(
   parameter int H_PIXELS    = 640,
   parameter int ADDR_W      = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              PCLK,
   input  logic              CamHsync,
   input  logic              CamVsync,
   input  logic [7:0]        CamData,
   output logic [ADDR_W-1:0] LB_WR_ADDR,
   output logic [15:0]       LB_WR_DATA,
   output logic              LB_WR_N,
   output logic              CamHsync_EDGE,
   output logic              CamVsync_EDGE,
   output logic [8:0]        CamLineCount,
   output logic              LineOverrun
);

   typedef enum logic [1:0] {IDLE, FRAME, LINE} state_t;

   localparam logic [ADDR_W:0] PIX_MAX = (ADDR_W+1)'(H_PIXELS);

   state_t state, stateNext;

   logic [SYNC_STAGES-1:0]      pclkSync, hrefSync, vsSync;
   logic [SYNC_STAGES-1:0][7:0] dataSync;
   logic                        pclkPrev, hrefPrev, vsPrev;
   logic                        pclkS, hrefS, vsS;
   logic [7:0]                  dataS;
   logic                        pclkRise, hrefFall, vsRise;

   logic [ADDR_W:0] pixCnt;
   logic            phase;
   logic [7:0]      hiByte;
   logic [15:0]     pixData;
   logic            latchHi, writePix, overrunHit;

   assign pclkS    = pclkSync[SYNC_STAGES-1];
   assign hrefS    = hrefSync[SYNC_STAGES-1];
   assign vsS      = vsSync[SYNC_STAGES-1];
   assign dataS    = dataSync[SYNC_STAGES-1];
   assign pclkRise = pclkS & ~pclkPrev;
   assign hrefFall = ~hrefS & hrefPrev;
   assign vsRise   = vsS & ~vsPrev;

`ifdef CAM_LINE_CAPTURE_TEST_PATTERN_EN
   logic [2:0] bar;
   assign bar     = pixCnt[ADDR_W-1:ADDR_W-3];
   assign pixData = {{5{bar[2]}}, {6{bar[1]}}, {5{bar[0]}}};
`else
   assign pixData = {hiByte, dataS};
`endif

   // Bring all camera inputs into CLK through equal-depth chains
   always_ff @(posedge CLK) begin
      if (RST) begin
         pclkSync <= '0;
         hrefSync <= '0;
         vsSync   <= '0;
         dataSync <= '0;
         pclkPrev <= 1'b0;
         hrefPrev <= 1'b0;
         vsPrev   <= 1'b0;
      end else begin
         pclkSync <= {pclkSync[SYNC_STAGES-2:0], PCLK};
         hrefSync <= {hrefSync[SYNC_STAGES-2:0], CamHsync};
         vsSync   <= {vsSync[SYNC_STAGES-2:0], CamVsync};
         dataSync <= {dataSync[SYNC_STAGES-2:0], CamData};
         pclkPrev <= pclkS;
         hrefPrev <= hrefS;
         vsPrev   <= vsS;
      end
   end

   // Capture state register
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= stateNext;
   end

   // Next state and per-byte capture decisions; vsync rise overrides all
   always_comb begin
      stateNext  = state;
      latchHi    = 1'b0;
      writePix   = 1'b0;
      overrunHit = 1'b0;
      if (vsRise) begin
         stateNext = FRAME;
      end else begin
         unique case (state)
            IDLE:    stateNext = IDLE;
            FRAME:   if (pclkRise && hrefS) stateNext = LINE;
            LINE:    if (hrefFall) stateNext = FRAME;
            default: stateNext = IDLE;
         endcase
         if (state != IDLE && hrefS && pclkRise) begin
            if (!phase)                latchHi    = 1'b1;
            else if (pixCnt == PIX_MAX) overrunHit = 1'b1;
            else                       writePix   = 1'b1;
         end
      end
   end

   // Byte pairing, write strobe, line/frame bookkeeping
   always_ff @(posedge CLK) begin
      if (RST) begin
         LB_WR_ADDR    <= '0;
         LB_WR_DATA    <= '0;
         LB_WR_N       <= 1'b1;
         CamHsync_EDGE <= 1'b0;
         CamVsync_EDGE <= 1'b0;
         CamLineCount  <= '0;
         LineOverrun   <= 1'b0;
         pixCnt        <= '0;
         phase         <= 1'b0;
         hiByte        <= '0;
      end else begin
         LB_WR_N       <= 1'b1;
         CamHsync_EDGE <= hrefFall;
         CamVsync_EDGE <= vsRise;
         if (vsRise) begin
            CamLineCount <= '0;
            pixCnt       <= '0;
            phase        <= 1'b0;
            LineOverrun  <= 1'b0;
         end else begin
            if (hrefFall && state != IDLE) begin
               pixCnt <= '0;
               phase  <= 1'b0;
               if (CamLineCount != 9'd511)
                  CamLineCount <= CamLineCount + 9'd1;
            end
            if (latchHi) begin
               hiByte <= dataS;
               phase  <= 1'b1;
            end
            if (writePix) begin
               LB_WR_N    <= 1'b0;
               LB_WR_ADDR <= pixCnt[ADDR_W-1:0];
               LB_WR_DATA <= pixData;
               pixCnt     <= pixCnt + 1'b1;
               phase      <= 1'b0;
            end
            if (overrunHit) begin
               LineOverrun <= 1'b1;
               phase       <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cam_line_capture.sv
// Scoreboard bench for cam_line_capture: directed camera lines,
// expected writes queued by stimulus and checked by a monitor.
module tb_cam_line_capture;

   logic        CLK = 1'b0;
   logic        RST;
   logic        PCLK;
   logic        CamHsync;
   logic        CamVsync;
   logic [7:0]  CamData;
   logic [9:0]  LB_WR_ADDR;
   logic [15:0] LB_WR_DATA;
   logic        LB_WR_N;
   logic        CamHsync_EDGE;
   logic        CamVsync_EDGE;
   logic [8:0]  CamLineCount;
   logic        LineOverrun;

   cam_line_capture dut (
      .CLK(CLK), .RST(RST), .PCLK(PCLK),
      .CamHsync(CamHsync), .CamVsync(CamVsync), .CamData(CamData),
      .LB_WR_ADDR(LB_WR_ADDR), .LB_WR_DATA(LB_WR_DATA), .LB_WR_N(LB_WR_N),
      .CamHsync_EDGE(CamHsync_EDGE), .CamVsync_EDGE(CamVsync_EDGE),
      .CamLineCount(CamLineCount), .LineOverrun(LineOverrun)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [9:0]  a;
      logic [15:0] d;
   } wr_t;

   wr_t expQ[$];
   int  tests = 0;
   int  fails = 0;
   int  hsCnt = 0;
   int  vsCnt = 0;
   int  wrCnt = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: count pulses and pop/compare every write strobe
   always @(posedge CLK) begin
      wr_t e;
      #1;
      if (CamHsync_EDGE === 1'b1) hsCnt++;
      if (CamVsync_EDGE === 1'b1) vsCnt++;
      if (RST === 1'b0 && LB_WR_N === 1'b0) begin
         wrCnt++;
         tests++;
         if (expQ.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: addr %0d data %h, none expected",
                     LB_WR_ADDR, LB_WR_DATA);
         end else begin
            e = expQ.pop_front();
            if (LB_WR_ADDR !== e.a || LB_WR_DATA !== e.d) begin
               fails++;
               $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                        LB_WR_ADDR, LB_WR_DATA, e.a, e.d);
            end
         end
      end
   end

   task automatic camByte(input logic [7:0] b);
      CamData = b;
      PCLK = 1'b0;
      repeat (2) @(negedge CLK);
      PCLK = 1'b1;
      repeat (2) @(negedge CLK);
   endtask

   task automatic vsPulse();
      CamVsync = 1'b1;
      repeat (4) @(negedge CLK);
      CamVsync = 1'b0;
      repeat (4) @(negedge CLK);
   endtask

   // Bytes base, base+1, ...; pairs below 640 are queued when doExp is set
   task automatic sendBytes(input int nBytes, input int base, input bit doExp);
      for (int i = 0; i < nBytes; i++) begin
         camByte(8'(base + i));
         if (doExp && (i % 2 == 1) && (i / 2 < 640))
            expQ.push_back('{10'(i / 2), {8'(base + i - 1), 8'(base + i)}});
      end
   endtask

   task automatic sendLine(input int nBytes, input int base, input bit doExp);
      CamHsync = 1'b1;
      repeat (2) @(negedge CLK);
      sendBytes(nBytes, base, doExp);
      PCLK = 1'b0;
      repeat (2) @(negedge CLK);
      CamHsync = 1'b0;
      repeat (6) @(negedge CLK);
   endtask

   int hs0, vs0, wr0;

   initial begin
      RST = 1'b1;
      PCLK = 1'b0;
      CamHsync = 1'b0;
      CamVsync = 1'b0;
      CamData = 8'h00;
      repeat (3) @(negedge CLK);
      check("rst_wr_n", LB_WR_N, 1);
      check("rst_addr", LB_WR_ADDR, 0);
      check("rst_data", LB_WR_DATA, 0);
      check("rst_lines", CamLineCount, 0);
      check("rst_overrun", LineOverrun, 0);
      check("rst_edges", {CamHsync_EDGE, CamVsync_EDGE}, 0);
      RST = 1'b0;
      repeat (3) @(negedge CLK);

      // HREF before any vsync: pulse only, no writes, no count
      sendLine(4, 8'h10, 1'b0);
      check("idle_hs_pulse", hsCnt, 1);
      check("idle_no_write", wrCnt, 0);
      check("idle_lines", CamLineCount, 0);

      vsPulse();
      check("vs_pulse1", vsCnt, 1);
      check("vs_lines0", CamLineCount, 0);

      // Full line of 1280 bytes
      sendLine(1280, 0, 1'b1);
      check("full_pending", expQ.size(), 0);
      check("full_writes", wrCnt, 640);
      check("full_lines", CamLineCount, 1);
      check("full_hs_pulse", hsCnt, 2);
      check("full_overrun", LineOverrun, 0);

      // Odd 5-byte line, next line restarts at address 0 phase 0
      sendLine(5, 8'hA0, 1'b1);
      check("odd_lines", CamLineCount, 2);
      sendLine(4, 8'hC0, 1'b1);
      check("odd_pending", expQ.size(), 0);
      check("after_odd_lines", CamLineCount, 3);

      // Over-long line
      wr0 = wrCnt;
      sendLine(1300, 0, 1'b1);
      check("ovr_pending", expQ.size(), 0);
      check("ovr_writes", wrCnt - wr0, 640);
      check("ovr_flag", LineOverrun, 1);
      check("ovr_lines", CamLineCount, 4);
      vsPulse();
      check("ovr_cleared", LineOverrun, 0);
      check("ovr_vs_lines", CamLineCount, 0);
      check("vs_pulse2", vsCnt, 2);

      // 480 short lines
      for (int k = 0; k < 480; k++) sendLine(2, k * 2, 1'b1);
      check("480_lines", CamLineCount, 480);
      check("480_pending", expQ.size(), 0);

      // Vsync rise in the same CLK as HREF fall
      hs0 = hsCnt;
      vs0 = vsCnt;
      CamHsync = 1'b1;
      repeat (2) @(negedge CLK);
      sendBytes(2, 8'h33, 1'b1);
      PCLK = 1'b0;
      repeat (2) @(negedge CLK);
      CamHsync = 1'b0;
      CamVsync = 1'b1;
      repeat (6) @(negedge CLK);
      check("sim_hs_pulse", hsCnt - hs0, 1);
      check("sim_vs_pulse", vsCnt - vs0, 1);
      check("sim_lines", CamLineCount, 0);
      CamVsync = 1'b0;
      repeat (4) @(negedge CLK);

      // Vsync rise mid-pair aborts the pending pair
      CamHsync = 1'b1;
      repeat (2) @(negedge CLK);
      sendBytes(3, 8'h50, 1'b1);
      CamVsync = 1'b1;
      repeat (4) @(negedge CLK);
      CamVsync = 1'b0;
      repeat (2) @(negedge CLK);
      camByte(8'h60);
      PCLK = 1'b0;
      repeat (2) @(negedge CLK);
      CamHsync = 1'b0;
      repeat (6) @(negedge CLK);
      check("abort_pending", expQ.size(), 0);
      check("abort_lines", CamLineCount, 1);

      // RST mid-line at pixel 300
      CamHsync = 1'b1;
      repeat (2) @(negedge CLK);
      sendBytes(600, 0, 1'b1);
      repeat (4) @(negedge CLK);
      check("pre_rst_pending", expQ.size(), 0);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      check("midrst_wr_n", LB_WR_N, 1);
      check("midrst_lines", CamLineCount, 0);
      check("midrst_addr", LB_WR_ADDR, 0);
      @(negedge CLK);
      RST = 1'b0;
      wr0 = wrCnt;
      sendBytes(6, 8'h70, 1'b0);
      PCLK = 1'b0;
      repeat (2) @(negedge CLK);
      CamHsync = 1'b0;
      repeat (6) @(negedge CLK);
      check("postrst_no_write", wrCnt - wr0, 0);
      check("postrst_lines", CamLineCount, 0);

      // Capture resumes after a fresh vsync
      vsPulse();
      sendLine(2, 8'h9A, 1'b1);
      check("resume_pending", expQ.size(), 0);
      check("resume_lines", CamLineCount, 1);

      repeat (4) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
